pe_core_sequencer: RTL

Control block for one 3x3 PE core. It loads the nine serial kernel weights and the bias into the core, drives the per-pixel `pulse` while the line buffer streams feature columns, and selects between bias and partial-sum accumulation. It also tracks the core's fixed pipeline latency so it can flag valid and last results on `feature_out`. It sits between the layer scheduler (configuration), the weight buffer (weight stream) and one PE core; the feature column bus goes straight from the line buffer to the core.

---
 rtl/pe_core_sequencer.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/pe_core_sequencer.sv
// pe_core_sequencer: control block for one 3x3 PE core.
// Loads KERNEL_SIZE serial weights and an optional bias, streams `pulse` per
// accepted feature column, and tracks the core's fixed pipeline latency to
// qualify the core's feature_out with out_valid/out_last.
// Optional feature macro: PE_SEQ_WEIGHT_REUSE_EN (adds cfg_reuse_w so a job
// can keep the kernel already held in the core and skip the weight load).
module pe_core_sequencer #(
    parameter int WEIGHT_WIDTH = 16,
    parameter int BIAS_WIDTH   = 32,
    parameter int KERNEL_SIZE  = 9,
    parameter int PIPE_LATENCY = 8,
    parameter int LEN_WIDTH    = 16
) (
    input  logic                    DSP_clk,
    input  logic                    rst,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [LEN_WIDTH-1:0]    cfg_len,
    input  logic                    cfg_bias_mode,
    input  logic [BIAS_WIDTH-1:0]   cfg_bias,
`ifdef PE_SEQ_WEIGHT_REUSE_EN
    input  logic                    cfg_reuse_w,
`endif
    input  logic                    w_valid,
    input  logic [WEIGHT_WIDTH-1:0] w_data,
    output logic                    w_ready,
    output logic [WEIGHT_WIDTH-1:0] weight,
    output logic                    weight_valid,
    output logic [BIAS_WIDTH-1:0]   bias,
    output logic                    bias_valid,
    output logic                    bias_or_adder_feature,
    input  logic                    feat_valid,
    output logic                    feat_ready,
    output logic                    pulse,
    output logic                    out_valid,
    output logic                    out_last,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_LOAD_B,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [3:0] W_LAST = 4'(KERNEL_SIZE - 1);
    // Output stage of the delay line; DRAIN only waits on the stages before it.
    localparam logic [PIPE_LATENCY-1:0] DL_TOP = PIPE_LATENCY'(1) << (PIPE_LATENCY - 1);

    state_t                  state_q, state_d;
    logic [LEN_WIDTH-1:0]    len_q, len_d;
    logic                    mode_q, mode_d;
    logic [BIAS_WIDTH-1:0]   bias_q, bias_d;
    logic [3:0]              w_cnt_q, w_cnt_d;
    logic [LEN_WIDTH-1:0]    px_cnt_q, px_cnt_d;
    logic [WEIGHT_WIDTH-1:0] weight_q, weight_d;
    logic                    weight_valid_q, weight_valid_d;
    logic [PIPE_LATENCY-1:0] dl_valid_q, dl_valid_d;
    logic [PIPE_LATENCY-1:0] dl_last_q, dl_last_d;

    logic px_last;
    logic early_pending;

    assign cfg_ready             = (state_q == S_IDLE);
    assign busy                  = (state_q != S_IDLE);
    assign w_ready               = (state_q == S_LOAD_W);
    assign bias_valid            = (state_q == S_LOAD_B);
    assign feat_ready            = (state_q == S_RUN);
    assign pulse                 = feat_valid & feat_ready;
    assign done                  = (state_q == S_DONE);
    assign weight                = weight_q;
    assign weight_valid          = weight_valid_q;
    assign bias                  = bias_q;
    assign bias_or_adder_feature = mode_q;
    assign out_valid             = dl_valid_q[PIPE_LATENCY-1];
    assign out_last              = dl_last_q[PIPE_LATENCY-1];

    assign px_last       = (px_cnt_q == len_q - LEN_WIDTH'(1));
    assign early_pending = |(dl_valid_q & ~DL_TOP);

    // State register.
    always_ff @(posedge DSP_clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic and job/config bookkeeping.
    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        mode_d         = mode_q;
        bias_d         = bias_q;
        w_cnt_d        = w_cnt_q;
        px_cnt_d       = px_cnt_q;
        weight_d       = weight_q;
        weight_valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cfg_valid) begin
                    len_d    = cfg_len;
                    mode_d   = cfg_bias_mode;
                    bias_d   = cfg_bias;
                    w_cnt_d  = '0;
                    px_cnt_d = '0;
                    state_d  = S_LOAD_W;
`ifdef PE_SEQ_WEIGHT_REUSE_EN
                    if (cfg_reuse_w) begin
                        if (cfg_bias_mode)      state_d = S_LOAD_B;
                        else if (cfg_len == '0) state_d = S_DONE;
                        else                    state_d = S_RUN;
                    end
`endif
                end
            end
            S_LOAD_W: begin
                if (w_valid) begin
                    weight_d       = w_data;
                    weight_valid_d = 1'b1;
                    w_cnt_d        = w_cnt_q + 4'd1;
                    if (w_cnt_q == W_LAST) begin
                        if (mode_q)           state_d = S_LOAD_B;
                        else if (len_q == '0) state_d = S_DONE;
                        else                  state_d = S_RUN;
                    end
                end
            end
            S_LOAD_B: begin
                state_d = (len_q == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                if (feat_valid) begin
                    px_cnt_d = px_cnt_q + LEN_WIDTH'(1);
                    if (px_last) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Leave as the final result reaches the output stage, so done
                // lands exactly one cycle after the last out_valid.
                if (!early_pending) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Latency-matching delay line carrying {pulse, is_last}.
    always_comb begin
        dl_valid_d    = '0;
        dl_last_d     = '0;
        dl_valid_d[0] = pulse;
        dl_last_d[0]  = pulse & px_last;
        for (int unsigned i = 1; i < PIPE_LATENCY; i++) begin
            dl_valid_d[i] = dl_valid_q[i-1];
            dl_last_d[i]  = dl_last_q[i-1];
        end
    end

    // Datapath registers.
    always_ff @(posedge DSP_clk or posedge rst) begin
        if (rst) begin
            len_q          <= '0;
            mode_q         <= 1'b0;
            bias_q         <= '0;
            w_cnt_q        <= '0;
            px_cnt_q       <= '0;
            weight_q       <= '0;
            weight_valid_q <= 1'b0;
            dl_valid_q     <= '0;
            dl_last_q      <= '0;
        end else begin
            len_q          <= len_d;
            mode_q         <= mode_d;
            bias_q         <= bias_d;
            w_cnt_q        <= w_cnt_d;
            px_cnt_q       <= px_cnt_d;
            weight_q       <= weight_d;
            weight_valid_q <= weight_valid_d;
            dl_valid_q     <= dl_valid_d;
            dl_last_q      <= dl_last_d;
        end
    end

endmodule
